mem_port_master: RTL

- Initiator side of the single-port synchronous RAM interface used in the CPU.
- Accepts load/store requests from the core over a valid/ready handshake and drives the RAM address, data and write-enable.
- Tracks the RAM's one-cycle registered read latency and returns read data in order through a first-word-fall-through response FIFO.
- Sustains one request per cycle while credit is available.

---
 rtl/mem_port_master.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_port_master.sv
// mem_port_master: core-side initiator for the single-port synchronous RAM.
// Ports: core req (valid/ready, write, addr, wdata), in-order load rsp
//   (valid/ready, data), busy, and RAM side (address, data_in, write, data_out).
`timescale 1ns/1ps
module mem_port_master #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     mem_write,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = CW + 1;

  logic                  rd_p1;
  logic                  rd_p2;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
  logic [NW-1:0]         pending;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Reserve a FIFO slot for every load in flight so a push always fits.
  assign pending = {1'b0, count}
                 + {{CW{1'b0}}, rd_p1}
                 + {{CW{1'b0}}, rd_p2};
  assign req_ready = pending < NW'(RSP_DEPTH);
  assign accept    = req_valid & req_ready;

  assign push      = rd_p2;
  assign rsp_valid = count != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? fifo[rd_ptr] : '0;
  assign busy      = rd_p1 | rd_p2 | rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
    end else begin
      mem_write <= accept & req_write;
      rd_p1     <= accept & ~req_write;
      rd_p2     <= rd_p1;
      if (accept) begin
        mem_address <= req_addr;
        mem_data_in <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_data_out;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CW'(RSP_DEPTH))
  );

endmodule
